// File: rtl/dump_pkg.sv
// dump_pkg: beat kind and FSM state encodings shared by the
// state dump streamer and its testbench.
package dump_pkg;

  typedef enum logic [1:0] {
    KIND_TIME = 2'd0,
    KIND_PC   = 2'd1,
    KIND_REG  = 2'd2,
    KIND_MEM  = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TIME = 3'd1,
    PC   = 3'd2,
    REGS = 3'd3,
    MEMS = 3'd4
  } state_e;

endpackage

// File: rtl/mask_next_index.sv
// mask_next_index: lowest set bit of MASK strictly above cur,
// with found low when no such bit exists.
module mask_next_index #(
  parameter int REG_AW = 5,
  parameter logic [(1<<REG_AW)-1:0] MASK = '1
) (
  input  logic [REG_AW-1:0] cur,
  output logic [REG_AW-1:0] nxt,
  output logic              found
);

  localparam int N = 1 << REG_AW;

  // Descending scan so the lowest qualifying bit is written last.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (MASK[i] && (i > int'(cur))) begin
        nxt   = REG_AW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/state_dump_streamer.sv
// state_dump_streamer: walks masked registers and a memory window and
// streams a framed snapshot (time, PC, regs, mem) over valid/ready.
module state_dump_streamer
  import dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 8,
  parameter int MEM_BASE = 0,
  parameter int MEM_WORDS = 32,
  parameter logic [(1<<REG_AW)-1:0] REG_MASK = 32'h3000_00E2,
  parameter int PERIOD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic [DATA_W-1:0] pc_in,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_kind,
  output logic [MEM_AW-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        overrun_cnt
);

  localparam logic [MEM_AW-1:0] MEM_FIRST = MEM_AW'(MEM_BASE);
  localparam logic [MEM_AW-1:0] MEM_LAST =
    MEM_AW'(MEM_BASE + MEM_WORDS - 1);

  state_e state, state_n;
  logic busy_n, pend, pend_n;
  logic [7:0] ovr_n;
  logic [31:0] cycle_cnt;
  logic [DATA_W-1:0] pc_lat, pc_n;
  logic [DATA_W-1:0] time_lat, time_n;
  logic [REG_AW-1:0] rad_n, nxt;
  logic [MEM_AW-1:0] mad_n, i_n;
  logic [DATA_W-1:0] d_n;
  logic [1:0] k_n;
  logic v_n, l_n;
  logic found, auto_tick, start, load, done;

  mask_next_index #(
    .REG_AW(REG_AW),
    .MASK  (REG_MASK)
  ) u_next (
    .cur  (reg_raddr),
    .nxt  (nxt),
    .found(found)
  );

  if (PERIOD > 0) begin : g_period
    logic [31:0] per_cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) per_cnt <= '0;
      else if (per_cnt == 32'(PERIOD - 1)) per_cnt <= '0;
      else per_cnt <= per_cnt + 32'd1;
    end
    assign auto_tick = (per_cnt == 32'(PERIOD - 1));
  end else begin : g_noperiod
    assign auto_tick = 1'b0;
  end

  assign start = trigger | auto_tick;
  assign load  = !out_valid || out_ready;
  assign done  = out_valid && out_ready && out_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy_n  = busy;
    pend_n  = pend;
    ovr_n   = overrun_cnt;
    time_n  = time_lat;
    pc_n    = pc_lat;
    rad_n   = reg_raddr;
    mad_n   = mem_raddr;
    v_n     = out_valid;
    d_n     = out_data;
    k_n     = out_kind;
    i_n     = out_idx;
    l_n     = out_last;
    if (load) begin
      v_n = 1'b0;
      l_n = 1'b0;
    end
    if (busy && start && !done) begin
      if (!pend) pend_n = 1'b1;
      else if (overrun_cnt != 8'hFF) ovr_n = overrun_cnt + 8'd1;
    end
    unique case (state)
      IDLE: begin
        if (!busy) begin
          if (start) begin
            time_n  = DATA_W'(cycle_cnt);
            pc_n    = pc_in;
            busy_n  = 1'b1;
            state_n = TIME;
          end
        end else if (done) begin
          // Chained snapshot: TIME beat replaces the accepted last beat.
          if (pend || start) begin
            v_n     = 1'b1;
            d_n     = DATA_W'(cycle_cnt);
            k_n     = KIND_TIME;
            i_n     = '0;
            pc_n    = pc_in;
            pend_n  = pend && start;
            state_n = PC;
          end else begin
            busy_n = 1'b0;
          end
        end
      end
      TIME: if (load) begin
        v_n     = 1'b1;
        d_n     = time_lat;
        k_n     = KIND_TIME;
        i_n     = '0;
        state_n = PC;
      end
      PC: if (load) begin
        v_n = 1'b1;
        d_n = pc_lat;
        k_n = KIND_PC;
        i_n = '0;
        if (REG_MASK == '0) begin
          state_n = MEMS;
        end else begin
          state_n = REGS;
          rad_n   = REG_MASK[0] ? '0 : nxt;
        end
      end
      REGS: if (load) begin
        v_n = 1'b1;
        d_n = reg_rdata;
        k_n = KIND_REG;
        i_n = MEM_AW'(reg_raddr);
        if (found) begin
          rad_n = nxt;
        end else begin
          rad_n   = '0;
          state_n = MEMS;
        end
      end
      MEMS: if (load) begin
        v_n = 1'b1;
        d_n = mem_rdata;
        k_n = KIND_MEM;
        i_n = mem_raddr;
        if (mem_raddr == MEM_LAST) begin
          l_n     = 1'b1;
          mad_n   = MEM_FIRST;
          state_n = IDLE;
        end else begin
          mad_n = mem_raddr + MEM_AW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      busy        <= 1'b0;
      pend        <= 1'b0;
      overrun_cnt <= '0;
      time_lat    <= '0;
      pc_lat      <= '0;
      reg_raddr   <= '0;
      mem_raddr   <= MEM_FIRST;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_kind    <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
    end else begin
      cycle_cnt   <= cycle_cnt + 32'd1;
      busy        <= busy_n;
      pend        <= pend_n;
      overrun_cnt <= ovr_n;
      time_lat    <= time_n;
      pc_lat      <= pc_n;
      reg_raddr   <= rad_n;
      mem_raddr   <= mad_n;
      out_valid   <= v_n;
      out_data    <= d_n;
      out_kind    <= k_n;
      out_idx     <= i_n;
      out_last    <= l_n;
    end
  end

endmodule

// File: tb/tb_state_dump_streamer.sv
// tb_state_dump_streamer: table, corner-case and randomized checks
// of three streamer configurations against a frame-level model.
module tb_state_dump_streamer;

  localparam logic [31:0] MASK = 32'h3000_00E2;

  typedef struct {
    logic [1:0]  kind;
    logic [7:0]  idx;
    logic [31:0] data;
    logic        last;
  } vec_t;

  typedef struct {
    logic [42:0] b;
    int          cyc;
  } rec_t;

  int total = 0;
  int bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r0, r1, r2, trig0, trig2, rdy0;
  logic zero = 1'b0;
  logic one = 1'b1;
  logic [31:0] pc0;
  logic [31:0] rf [32];
  logic [31:0] mem [256];

  logic [4:0] ra0, ra1, ra2;
  logic [7:0] ma0, ma1, ma2;
  logic [31:0] rd0, rd1, rd2, md0, md1, md2;
  logic v0, v1, v2, l0, l1, l2, b0, b1, b2;
  logic [31:0] d0, d1, d2;
  logic [1:0] k0, k1, k2;
  logic [7:0] i0, i1, i2, ov0, ov1, ov2;

  assign rd0 = rf[ra0];
  assign md0 = mem[ma0];
  assign rd1 = rf[ra1];
  assign md1 = mem[ma1];
  assign rd2 = rf[ra2];
  assign md2 = mem[ma2];

  state_dump_streamer #(.MEM_WORDS(4)) u0 (
    .clk(clk), .reset(r0), .trigger(trig0), .pc_in(pc0),
    .reg_raddr(ra0), .reg_rdata(rd0),
    .mem_raddr(ma0), .mem_rdata(md0),
    .out_valid(v0), .out_ready(rdy0), .out_data(d0),
    .out_kind(k0), .out_idx(i0), .out_last(l0),
    .busy(b0), .overrun_cnt(ov0));

  state_dump_streamer #(.MEM_WORDS(4), .PERIOD(20)) u1 (
    .clk(clk), .reset(r1), .trigger(zero), .pc_in(pc0),
    .reg_raddr(ra1), .reg_rdata(rd1),
    .mem_raddr(ma1), .mem_rdata(md1),
    .out_valid(v1), .out_ready(one), .out_data(d1),
    .out_kind(k1), .out_idx(i1), .out_last(l1),
    .busy(b1), .overrun_cnt(ov1));

  state_dump_streamer #(
    .REG_MASK(32'h0), .MEM_BASE(8), .MEM_WORDS(2)
  ) u2 (
    .clk(clk), .reset(r2), .trigger(trig2), .pc_in(pc0),
    .reg_raddr(ra2), .reg_rdata(rd2),
    .mem_raddr(ma2), .mem_rdata(md2),
    .out_valid(v2), .out_ready(one), .out_data(d2),
    .out_kind(k2), .out_idx(i2), .out_last(l2),
    .busy(b2), .overrun_cnt(ov2));

  int cyc0;
  always @(posedge clk or posedge r0)
    if (r0) cyc0 <= 0;
    else cyc0 <= cyc0 + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  rec_t q0[$];
  rec_t q2[$];
  logic [31:0] t1[$];
  logic [42:0] expq[$];
  logic stl = 1'b0;
  logic [42:0] hold;

  // Accepted-beat capture and stall-stability check for u0.
  always @(negedge clk) begin
    if (r0) begin
      stl = 1'b0;
    end else begin
      if (stl) chk("hold", {20'd0, v0, k0, i0, d0, l0}, {20'd0, 1'b1, hold});
      if (v0 && rdy0) q0.push_back('{{k0, i0, d0, l0}, cyc0});
      stl  = v0 && !rdy0;
      hold = {k0, i0, d0, l0};
    end
  end

  always @(negedge clk) begin
    if (!r2 && v2) q2.push_back('{{k2, i2, d2, l2}, cyc0});
    if (!r1 && v1 && k1 == 2'd0) t1.push_back(d1);
  end

  function automatic logic [42:0] getb(input int i);
    if (i < q0.size()) return q0[i].b;
    return 'x;
  endfunction

  task automatic build_exp(input logic [31:0] t, input logic [31:0] pc);
    expq.delete();
    expq.push_back({2'd0, 8'd0, t, 1'b0});
    expq.push_back({2'd1, 8'd0, pc, 1'b0});
    for (int r = 0; r < 32; r++)
      if (MASK[r]) expq.push_back({2'd2, 8'(r), rf[r], 1'b0});
    for (int a = 0; a < 4; a++)
      expq.push_back({2'd3, 8'(a), mem[a], a == 3});
  endtask

  task automatic cmp_frame(input string nm, input int off);
    for (int i = 0; i < expq.size(); i++)
      chk(nm, {21'd0, getb(off + i)}, {21'd0, expq[i]});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_beats(input int n, input int budget, input bit rnd);
    int c = 0;
    while (q0.size() < n && c < budget) begin
      tick();
      if (rnd) rdy0 = 1'($urandom_range(0, 1));
      c++;
    end
    rdy0 = 1'b1;
    chk("beat_count", 64'(q0.size()), 64'(n));
  endtask

  task automatic pulse_trig0();
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
  endtask

  vec_t tbl[12];
  vec_t tbl2[4];
  int regs[6] = '{1, 5, 6, 7, 28, 29};
  int tc, c;
  int nl;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    pc0 = 32'h0000_1234;
    trig0 = 1'b0;
    trig2 = 1'b0;
    rdy0 = 1'b1;
    r0 = 1'b1;
    r1 = 1'b1;
    r2 = 1'b1;

    tbl[0] = '{2'd0, 8'd0, 32'd3, 1'b0};
    tbl[1] = '{2'd1, 8'd0, 32'h0000_1234, 1'b0};
    for (int j = 0; j < 6; j++)
      tbl[2+j] = '{2'd2, 8'(regs[j]), rf[regs[j]], 1'b0};
    for (int j = 0; j < 4; j++)
      tbl[8+j] = '{2'd3, 8'(j), mem[j], j == 3};
    tbl2[0] = '{2'd0, 8'd0, 32'd3, 1'b0};
    tbl2[1] = '{2'd1, 8'd0, 32'h0000_1234, 1'b0};
    tbl2[2] = '{2'd3, 8'd8, mem[8], 1'b0};
    tbl2[3] = '{2'd3, 8'd9, mem[9], 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    r0 = 1'b0;
    r1 = 1'b0;
    r2 = 1'b0;
    #1;
    chk("rst_valid", 64'(v0), 0);
    chk("rst_data", 64'(d0), 0);
    chk("rst_kind", 64'(k0), 0);
    chk("rst_idx", 64'(i0), 0);
    chk("rst_last", 64'(l0), 0);
    chk("rst_busy", 64'(b0), 0);
    chk("rst_ovr", 64'(ov0), 0);
    chk("rst_raddr", 64'(ra0), 0);
    chk("rst_maddr", 64'(ma0), 0);
    chk("rst_maddr_base", 64'(ma2), 8);

    // Single snapshot, trigger in cycle 3.
    repeat (3) tick();
    trig0 = 1'b1;
    trig2 = 1'b1;
    tick();
    trig0 = 1'b0;
    trig2 = 1'b0;
    chk("busy_start", 64'(b0), 1);
    chk("valid_start", 64'(v0), 0);
    wait_beats(12, 40, 1'b0);
    chk("busy_end", 64'(b0), 0);
    for (int i = 0; i < 12; i++)
      chk("tbl", {21'd0, getb(i)},
          {21'd0, tbl[i].kind, tbl[i].idx, tbl[i].data, tbl[i].last});
    if (q0.size() == 12) begin
      chk("first_cyc", 64'(q0[0].cyc), 5);
      chk("last_cyc", 64'(q0[11].cyc), 16);
    end
    chk("u2_count", 64'(q2.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("tbl_u2", {21'd0, (i < q2.size()) ? q2[i].b : 43'bx},
          {21'd0, tbl2[i].kind, tbl2[i].idx, tbl2[i].data, tbl2[i].last});
    chk("u2_busy", 64'(b2), 0);

    // Three-cycle stall on the PC beat.
    q0.delete();
    tick();
    tc = cyc0;
    pulse_trig0();
    c = 0;
    while (!(v0 && k0 == 2'd1) && c < 20) begin
      tick();
      c++;
    end
    chk("pc_seen", 64'(v0 && k0 == 2'd1), 1);
    rdy0 = 1'b0;
    repeat (3) tick();
    rdy0 = 1'b1;
    wait_beats(12, 40, 1'b0);
    build_exp(32'(tc), pc0);
    cmp_frame("stall", 0);
    if (q0.size() == 12) chk("stall_gap", 64'(q0[1].cyc - q0[0].cyc), 4);

    // Triggers in cycles 3, 5, 7: chained frames plus one overrun.
    q0.delete();
    r0 = 1'b1;
    @(negedge clk);
    r0 = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 6; k++) begin
      trig0 = (k % 2 == 0);
      tick();
    end
    trig0 = 1'b0;
    wait_beats(24, 60, 1'b0);
    chk("busy_chain_end", 64'(b0), 0);
    chk("ovr_chain", 64'(ov0), 1);
    for (int i = 0; i < 12; i++)
      chk("chain1", {21'd0, getb(i)},
          {21'd0, tbl[i].kind, tbl[i].idx, tbl[i].data, tbl[i].last});
    build_exp(32'd16, pc0);
    cmp_frame("chain2", 12);
    if (q0.size() == 24) begin
      chk("chain_contig", 64'(q0[12].cyc), 17);
      chk("chain_end_cyc", 64'(q0[23].cyc), 28);
    end

    // Reset in the middle of the register beats.
    q0.delete();
    for (int k = 0; k < 5; k++) begin
      trig0 = (k % 2 == 0);
      tick();
    end
    trig0 = 1'b0;
    c = 0;
    while (!(v0 && k0 == 2'd2) && c < 20) begin
      tick();
      c++;
    end
    chk("ovr_pre_rst", 64'(ov0), 2);
    chk("reg_seen", 64'(v0 && k0 == 2'd2), 1);
    r0 = 1'b1;
    #1;
    chk("midrst_valid", 64'(v0), 0);
    chk("midrst_busy", 64'(b0), 0);
    chk("midrst_ovr", 64'(ov0), 0);
    nl = 0;
    foreach (q0[i]) if (q0[i].b[0]) nl++;
    chk("midrst_nolast", 64'(nl), 0);
    @(negedge clk);
    r0 = 1'b0;
    q0.delete();
    repeat (2) tick();
    tc = cyc0;
    pulse_trig0();
    wait_beats(12, 40, 1'b0);
    build_exp(32'(tc), pc0);
    cmp_frame("post_rst", 0);
    repeat (4) tick();
    chk("post_rst_idle", 64'(q0.size()), 12);
    chk("post_rst_busy", 64'(b0), 0);

    // Randomized contents, PC and back-pressure.
    for (int f = 0; f < 6; f++) begin
      q0.delete();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = $urandom;
      pc0 = $urandom;
      repeat ($urandom_range(1, 4)) tick();
      tc = cyc0;
      pulse_trig0();
      wait_beats(12, 300, 1'b1);
      build_exp(32'(tc), pc0);
      cmp_frame("rand", 0);
      chk("rand_busy", 64'(b0), 0);
    end

    // Periodic instance: first three TIME words.
    c = 0;
    while (t1.size() < 3 && c < 100) begin
      tick();
      c++;
    end
    chk("per_count", 64'(t1.size() >= 3), 1);
    chk("per_t0", 64'((t1.size() > 0) ? t1[0] : 'x), 19);
    chk("per_t1", 64'((t1.size() > 1) ? t1[1] : 'x), 39);
    chk("per_t2", 64'((t1.size() > 2) ? t1[2] : 'x), 59);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/state_dump_streamer.md
# state_dump_streamer

Synthesisable successor to the simulation-only register/memory dump: on a trigger (external pulse or built-in period), walks a programmable subset of the register file and a window of data memory through their read ports. It then emits a framed snapshot over a valid/ready stream (time word, PC, registers, memory words). It sits beside the pipelined core, sharing a spare register-file read port and a data-memory read port, and feeds a UART/trace sink.

## Interface
- DATA_W, 32, data/stream word width
- REG_AW, 5, register address width
- MEM_AW, 8, data-memory word-address width; must be >= REG_AW
- MEM_BASE, 0, first memory word dumped
- MEM_WORDS, 32, memory words dumped per snapshot; 1..2^MEM_AW-MEM_BASE
- REG_MASK, 32'h3000_00E2, bit i set means register i is dumped (default: x1, x5–x7, x28, x29)
- PERIOD, 0, auto-trigger interval in cycles; 0 disables it

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- trigger  in  1  snapshot request pulse
- pc_in  in  DATA_W  current IF PC
- reg_raddr  out  REG_AW  register read address
- reg_rdata  in  DATA_W  combinational read data
- mem_raddr  out  MEM_AW  memory read address
- mem_rdata  in  DATA_W  combinational read data
- out_valid  out  1  stream beat valid
- out_ready  in  1  sink accepts beat
- out_data  out  DATA_W  beat payload
- out_kind  out  2  0=TIME, 1=PC, 2=REG, 3=MEM
- out_idx  out  MEM_AW  register number or memory word address; 0 for headers
- out_last  out  1  final beat of snapshot
- busy  out  1  snapshot in progress
- overrun_cnt  out  8  dropped-trigger count, saturating at 255

## Operation
- FSM states: IDLE, TIME, PC, REGS, MEMS. A snapshot runs IDLE→TIME→PC→REGS→MEMS→IDLE.
- REGS is skipped if REG_MASK==0.
- In REGS, the index advances to the next set mask bit strictly above the current one. When no set bit remains above the current index, the FSM moves to MEMS.
- Free-running 32-bit cycle_cnt: 0 in the first cycle after reset, wraps at 2^32.
- Start request = trigger OR auto_tick.
  - auto_tick is high in the cycle the period counter (0..PERIOD-1) equals PERIOD-1.
- On a start request in IDLE: latch cycle_cnt and pc_in from that cycle, then enter TIME.
- Start request while busy:
  - If the pending flag is clear, set it.
  - If pending is already set, increment overrun_cnt (saturating).
  - When the snapshot completes with pending set, go straight to TIME without an IDLE cycle. The latched time and PC are taken at the completion edge.
  - A start request in the same cycle pending is consumed re-sets pending.
- Output register loads a new beat when !out_valid || out_ready.
  - REG and MEM beats are loaded from the combinational read data at the address driven in that cycle.
  - reg_raddr and mem_raddr are held stable while out_valid && !out_ready.
- out_last is high only on the MEM beat at MEM_BASE+MEM_WORDS-1.
- Register 0 is dumped if its mask bit is set; its value is whatever reg_rdata returns.

## Timing
- Reset values: out_valid=0, out_data=0, out_kind=0, out_idx=0, out_last=0, busy=0, overrun_cnt=0, reg_raddr=0, mem_raddr=MEM_BASE. FSM is IDLE, pending=0, cycle_cnt=0, period counter=0.
- Start request sampled at edge t: busy=1 and the TIME beat is valid after edge t+1.
- Back-to-back throughput with out_ready=1 is one beat per cycle. A snapshot is 2+popcount(REG_MASK)+MEM_WORDS beats.
- busy falls on the edge that accepts the out_last beat, unless pending is set.
- out_data, out_kind, out_idx and out_last are stable while out_valid && !out_ready; no beat is ever dropped or duplicated.
- Reset asserted mid-snapshot forces the reset values immediately; the partial frame is discarded and no out_last is issued.
- Memory reads see same-cycle contents; stores landing during a snapshot may appear in it. No coherence guarantee.

## Structure
- Shared package dump_pkg: kind encodings KIND_TIME, KIND_PC, KIND_REG, KIND_MEM; FSM state encoding.
- Sub-module mask_next_index: combinational search returning the next set bit of REG_MASK above a given index, plus a found flag.

## Test plan
- Default params with MEM_WORDS=4, trigger at cycle 3, out_ready=1 → 12 beats: TIME=3, PC=pc_in, REG idx 1,5,6,7,28,29, MEM idx 0..3. out_last only on idx 3; busy low after the 12th beat.
- Same config, out_ready low for 3 cycles at the PC beat → beat payload held unchanged, all 12 beats delivered in order.
- Triggers at cycles 3, 5 and 7 → two contiguous snapshots with no gap between them, overrun_cnt=1. Second TIME word equals the cycle of the first snapshot's completion edge.
- PERIOD=20, MEM_WORDS=4, trigger tied low → snapshots start with TIME words 19, 39, 59.
- Reset pulsed during the REG beats → out_valid, busy and overrun_cnt drop to 0 at once; the next trigger produces a full frame starting with TIME.
- REG_MASK=0, MEM_BASE=8, MEM_WORDS=2 → beats TIME, PC, MEM idx 8, MEM idx 9 with out_last on idx 9.
